// File: rtl/emitter_fifo_pkg.sv
// Shared field positions, select codes and word builders for the emitter FIFO.
package emitter_fifo_pkg;

  localparam int DATA_W   = 8;
  localparam int ENTRY_W  = 9;
  localparam int WORD_W   = 10;

  localparam int VALID_BIT = 9;
  localparam int LAST_BIT  = 8;
  localparam int DATA_MSB  = 7;
  localparam int OVF_BIT   = 9;

  localparam logic SEL_STATUS = 1'b0;
  localparam logic SEL_POP    = 1'b1;

  // Pop word: valid flag on top of the stored {last, data} entry.
  function automatic logic [WORD_W-1:0] pop_word(input logic [ENTRY_W-1:0] entry);
    logic [WORD_W-1:0] w;
    w                 = '0;
    w[VALID_BIT]      = 1'b1;
    w[LAST_BIT]       = entry[LAST_BIT];
    w[DATA_MSB:0]     = entry[DATA_MSB:0];
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] status_word(input logic ovf,
                                                    input logic [ENTRY_W-1:0] lvl);
    logic [WORD_W-1:0] w;
    w              = '0;
    w[OVF_BIT]     = ovf;
    w[ENTRY_W-1:0] = lvl;
    return w;
  endfunction

endpackage

// File: rtl/emitter_fifo_ram.sv
// Entry storage for the emitter FIFO: synchronous write, asynchronous read.
module emitter_fifo_ram
  import emitter_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [ENTRY_W-1:0]    wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [ENTRY_W-1:0]    rd_data
);

  logic [ENTRY_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/emitter_fifo.sv
// Byte-stream FIFO on the emitter mux FIFO slave port; stream in, Wishbone-style status/pop out.
// Define EMITTER_FIFO_OVF_EN to drop beats when full and flag a sticky overflow instead of backpressure.
module emitter_fifo
  import emitter_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              o_tready,
  input  logic              i_wb_sel,
  input  logic              i_wb_stb,
  output logic [WORD_W-1:0] o_wb_rdt,
  output logic              o_wb_ack
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  full;
  logic                  empty;
  logic                  accept;
  logic                  wr_en;
  logic                  pop;
  logic                  ovf_set;
  logic [ENTRY_W-1:0]    rd_entry;

  assign full   = (level == LEVEL_FULL);
  assign empty  = (level == '0);
  // Ack blocks re-acceptance so a held strobe cannot pop twice.
  assign accept = i_wb_stb & ~o_wb_ack;
  assign pop    = accept & (i_wb_sel == SEL_POP) & ~empty;
  assign wr_en  = i_tvalid & ~full;

`ifdef EMITTER_FIFO_OVF_EN
  assign o_tready = 1'b1;
  assign ovf_set  = i_tvalid & full;
`else
  assign o_tready = ~full;
  assign ovf_set  = 1'b0;
`endif

  emitter_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({i_tlast, i_tdata}),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
      overflow <= 1'b0;
    end else begin
      o_wb_ack <= accept;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (accept) begin
        if (i_wb_sel == SEL_POP)
          o_wb_rdt <= empty ? '0 : pop_word(rd_entry);
        else
          o_wb_rdt <= status_word(overflow, 9'(level));
      end
      // A fresh overflow outranks the clear-on-status-read.
      if (ovf_set)
        overflow <= 1'b1;
      else if (accept && (i_wb_sel == SEL_STATUS))
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_emitter_fifo.sv
// Directed bench for emitter_fifo with a queue-based reference model checked every cycle.
module tb_emitter_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tdata = 8'h00;
  logic       tlast = 1'b0;
  logic       tvalid = 1'b0;
  logic       sel = 1'b0;
  logic       stb = 1'b0;
  logic       tready;
  logic [9:0] rdt;
  logic       ack;

  int n_cmp = 0;
  int n_bad = 0;

  emitter_fifo #(.DEPTH_LOG2(DL)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_tdata  (tdata),
    .i_tlast  (tlast),
    .i_tvalid (tvalid),
    .o_tready (tready),
    .i_wb_sel (sel),
    .i_wb_stb (stb),
    .o_wb_rdt (rdt),
    .o_wb_ack (ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {last,data}, plus the expected ack/rdt/overflow.
  logic [8:0] mq[$];
  logic       m_ack = 1'b0;
  logic [9:0] m_rdt = 10'h000;
  logic       m_ovf = 1'b0;
  logic       m_live = 1'b0;
  logic       m_acc;
  logic       m_full;
  int         m_sz;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ack  = 1'b0;
      m_rdt  = 10'h000;
      m_ovf  = 1'b0;
      m_live = 1'b1;
    end else begin
      m_sz   = mq.size();
      m_full = (m_sz == DEPTH);
      m_acc  = stb && !m_ack;
      if (m_acc) begin
        if (sel) begin
          if (m_sz > 0) m_rdt = {1'b1, mq.pop_front()};
          else          m_rdt = 10'h000;
        end else begin
          m_rdt = {m_ovf, 9'(m_sz)};
        end
      end
`ifdef EMITTER_FIFO_OVF_EN
      if (tvalid && m_full)      m_ovf = 1'b1;
      else if (m_acc && !sel)    m_ovf = 1'b0;
`endif
      if (tvalid && !m_full) mq.push_back({tlast, tdata});
      m_ack = m_acc;
    end
  end

  always @(negedge clk) begin
    if (m_live && !rst) begin
      chk("cyc_ack", 32'(ack), 32'(m_ack));
      if (m_ack) chk("cyc_rdt", 32'(rdt), 32'(m_rdt));
`ifdef EMITTER_FIFO_OVF_EN
      chk("cyc_tready", 32'(tready), 32'd1);
`else
      chk("cyc_tready", 32'(tready), 32'(mq.size() < DEPTH));
`endif
    end
  end

  task automatic wb_read(input logic s, output logic [9:0] d, input bit hold_check);
    int n;
    n   = 0;
    stb = 1'b1;
    sel = s;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 10);
    chk("ack_latency", 32'(n), 32'd1);
    d = rdt;
    if (hold_check) begin
      @(negedge clk);
      chk("ack_drop_with_stb_held", 32'(ack), 32'd0);
    end
    stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int n;
    n      = 0;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    while (!tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", 32'(n), 32'd0);
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  logic [9:0] d;
  logic [7:0] b;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdt", 32'(rdt), 32'h000);
    chk("rst_tready", 32'(tready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Status read right after reset, strobe held past the ack.
    wb_read(1'b0, d, 1'b1);
    chk("t1_status", 32'(d), 32'h000);

    push(8'hA5, 1'b0);
    push(8'h3C, 1'b1);
    wb_read(1'b1, d, 1'b0);
    chk("t2_pop0", 32'(d), 32'h2A5);
    wb_read(1'b1, d, 1'b0);
    chk("t2_pop1", 32'(d), 32'h33C);
    wb_read(1'b0, d, 1'b0);
    chk("t2_status", 32'(d), 32'h000);

    wb_read(1'b1, d, 1'b0);
    chk("t3_pop_empty", 32'(d), 32'h000);
    wb_read(1'b0, d, 1'b0);
    chk("t3_level", 32'(d), 32'h000);
    // Pop of the empty FIFO in the same cycle a beat is written.
    tdata = 8'h11; tlast = 1'b0; tvalid = 1'b1;
    stb = 1'b1; sel = 1'b1;
    @(negedge clk);
    tvalid = 1'b0;
    chk("t3_same_ack", 32'(ack), 32'd1);
    chk("t3_same_rdt", 32'(rdt), 32'h000);
    stb = 1'b0;
    @(negedge clk);
    wb_read(1'b1, d, 1'b0);
    chk("t3_next_pop", 32'(d), 32'h211);

`ifndef EMITTER_FIFO_OVF_EN
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i), 1'(i == 15));
    chk("t4_full_tready", 32'(tready), 32'd0);
    wb_read(1'b0, d, 1'b0);
    chk("t4_status_full", 32'(d), 32'h010);
    tdata = 8'h77; tlast = 1'b0; tvalid = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_held_tready", 32'(tready), 32'd0);
    stb = 1'b1; sel = 1'b1;
    @(negedge clk);
    chk("t4_pop_ack", 32'(ack), 32'd1);
    chk("t4_pop_rdt", 32'(rdt), 32'h240);
    chk("t4_tready_back", 32'(tready), 32'd1);
    stb = 1'b0;
    @(negedge clk);
    tvalid = 1'b0;
    chk("t4_refull_tready", 32'(tready), 32'd0);
    wb_read(1'b0, d, 1'b0);
    chk("t4_status_refull", 32'(d), 32'h010);
    for (int i = 0; i < 16; i++) begin
      wb_read(1'b1, d, 1'b0);
      if (i == 14) chk("t4_drain_last", 32'(d), 32'h34F);
      if (i == 15) chk("t4_drain_held", 32'(d), 32'h277);
    end
`endif

    for (int i = 0; i < 40; i++) begin
      b = 8'(i * 7 + 3);
      push(b, 1'b0);
      wb_read(1'b1, d, 1'b0);
      chk("t5_wrap_pop", 32'(d), 32'({2'b10, b}));
      wb_read(1'b0, d, 1'b0);
      chk("t5_wrap_level", 32'(d), 32'h000);
    end

    // Reset during an outstanding request drops it and clears the pointers.
    push(8'h55, 1'b1);
    stb = 1'b1; sel = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_rdt", 32'(rdt), 32'h000);
    stb = 1'b0; rst = 1'b0;
    @(negedge clk);
    wb_read(1'b0, d, 1'b0);
    chk("rst_mid_level", 32'(d), 32'h000);

`ifdef EMITTER_FIFO_OVF_EN
    for (int i = 0; i < 17; i++) push(8'(8'h60 + i), 1'b0);
    wb_read(1'b0, d, 1'b0);
    chk("t6_status_ovf", 32'(d), 32'h210);
    wb_read(1'b0, d, 1'b0);
    chk("t6_status_clr", 32'(d), 32'h010);
    for (int i = 0; i < 16; i++) begin
      wb_read(1'b1, d, 1'b0);
      if (i == 0)  chk("t6_first", 32'(d), 32'h260);
      if (i == 15) chk("t6_last", 32'(d), 32'h26F);
    end
    wb_read(1'b1, d, 1'b0);
    chk("t6_dropped", 32'(d), 32'h000);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
